shoe_dealer: RTL and testbench
==============================

// Module: shoe_dealer
// PURPOSE
//   Card source for the baccarat datapath. Deals 4-bit card codes (1=Ace .. 10/J/Q/K = 10..13)
//   without replacement from a shoe of NUM_DECKS decks. Downstream hand scoring consumes them.
//   A free-running rank counter supplies the randomness, sampled when the player presses deal.
//   The block tracks the remaining count for each rank. If the sampled rank is exhausted,
//   it searches forward to the next rank that still has cards.
// PARAMETERS
//   NUM_DECKS  1  decks in the shoe, legal 1..8; per-rank count = 4*NUM_DECKS, total = 52*NUM_DECKS
// PORTS
//   clock       in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   deal_req    in   1  request one card; sampled only in IDLE
//   shuffle     in   1  refill the shoe to full; sampled every cycle
//   card        out  4  last dealt card code; 0 = none dealt since reset/shuffle
//   card_valid  out  1  one-cycle pulse: card updated this cycle
//   deal_err    out  1  one-cycle pulse: request made while shoe empty
//   busy        out  1  high while in SEARCH (combinational decode of state)
//   shoe_empty  out  1  cards_left == 0 (combinational)
//   cards_left  out  9  cards remaining in shoe, 0..416
// BEHAVIOUR
//   Reset (async, immediate):
//     state=IDLE, rank_ctr=1, all 13 rank counts=4*NUM_DECKS, cards_left=52*NUM_DECKS,
//     card=0, card_valid=0, deal_err=0.
//   rank_ctr: increments every clock in every state; wraps 13 -> 1; never holds 0 or 14..15.
//   card_valid and deal_err default to 0 every cycle unless set below.
//   State IDLE:
//     - shuffle=1: reload all counts and cards_left, card<=0; stay IDLE. shuffle has priority over deal_req.
//     - deal_req=1 and shoe_empty: deal_err<=1; stay IDLE.
//     - deal_req=1 and not empty: cand<=rank_ctr (value before this edge's increment); go SEARCH.
//   State SEARCH (one rank examined per cycle):
//     - shuffle=1: abort; reload as in IDLE; no card_valid; go IDLE.
//     - count[cand] > 0: decrement count[cand] and cards_left; card<=cand, card_valid<=1; go IDLE.
//     - count[cand] == 0: cand<=cand+1 (wrap 13 -> 1); stay SEARCH.
//     - deal_req is ignored in SEARCH.
//     - Search always terminates within 13 cycles, since cards_left>0 on entry.
//   Latency: deal_req sampled at edge k. card_valid is high in the cycle after edge k+1+m,
//     where m = exhausted ranks skipped (0..12). Minimum 2 edges, maximum 14.
//   deal_req held high: a new deal starts in each IDLE cycle, including the cycle in which
//     card_valid is high, giving back-to-back deals.
//   Counters never underflow. cards_left == sum of the 13 rank counts at all times.
//   card holds its value between deals.
//   Per-rank counts are 6 bits wide. Decrement is performed only when count > 0.
// TESTING
//   1. reset, NUM_DECKS=1 -> cards_left=52, card=0, card_valid=0, shoe_empty=0, busy=0; rank_ctr sequence 1..13,1.
//   2. deal_req one cycle while rank_ctr=5 -> card=5 with card_valid 2 edges later, cards_left=51, busy high 1 cycle.
//   3. Deplete rank 7 (4 deals), then deal_req at rank_ctr=7 -> card=8, latency 3 edges;
//      deplete 7..13, request at 13 -> card wraps to 1.
//   4. Hold deal_req for 52 deals -> each rank dealt exactly 4 times, shoe_empty=1;
//      53rd request -> deal_err pulse, no card_valid.
//   5. shuffle asserted mid-SEARCH -> no card_valid, cards_left=52, card=0, state IDLE next cycle;
//      shuffle and deal_req together in IDLE -> shuffle only.
//   6. reset asserted between edges mid-SEARCH -> all outputs at reset values before the next edge;
//      NUM_DECKS=8 -> cards_left=416 after reset.

Source files
------------

// File: rtl/shoe_dealer.sv
// Card shoe for the baccarat datapath: deals rank codes 1..13 without replacement,
// seeded by a free-running rank counter and skipping forward past exhausted ranks.
module shoe_dealer #(
  parameter int NUM_DECKS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       deal_err,
  output logic       busy,
  output logic       shoe_empty,
  output logic [8:0] cards_left
);

  localparam logic [5:0] RANK_FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        rank_ctr_reg;
  logic [3:0]        cand_reg;
  logic [3:0]        card_reg;
  logic              card_valid_reg;
  logic              deal_err_reg;
  logic [8:0]        cards_left_reg;
  logic [12:0][5:0]  count;
  logic              cand_avail;
  logic              start_deal;
  logic              take_card;
  logic              skip_rank;

  // Is there still a card of the rank currently under examination?
  always_comb begin
    cand_avail = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (cand_reg == 4'(i + 1) && count[i] != 6'd0) cand_avail = 1'b1;
    end
  end

  assign start_deal = (state_reg == IDLE)   && !shuffle && deal_req && !shoe_empty;
  assign take_card  = (state_reg == SEARCH) && !shuffle && cand_avail;
  assign skip_rank  = (state_reg == SEARCH) && !shuffle && !cand_avail;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_deal) state_next = SEARCH;
      SEARCH:  if (shuffle || cand_avail) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_reg == SEARCH);
  end

  // Free-running randomness source; cycles 1..13 regardless of state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      rank_ctr_reg <= 4'd1;
    else if (rank_ctr_reg == 4'd13) rank_ctr_reg <= 4'd1;
    else                            rank_ctr_reg <= rank_ctr_reg + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           cand_reg <= 4'd1;
    else if (start_deal) cand_reg <= rank_ctr_reg;
    else if (skip_rank)  cand_reg <= (cand_reg == 4'd13) ? 4'd1 : cand_reg + 4'd1;
  end

  // One counter per rank; only the rank being dealt is decremented.
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_rank
      logic [5:0] cnt_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)                                         cnt_reg <= RANK_FULL;
        else if (shuffle)                                  cnt_reg <= RANK_FULL;
        else if (take_card && cand_reg == 4'(gi + 1) && cnt_reg != 6'd0)
                                                           cnt_reg <= cnt_reg - 6'd1;
      end
      assign count[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cards_left_reg <= SHOE_FULL;
      card_reg       <= 4'd0;
      card_valid_reg <= 1'b0;
      deal_err_reg   <= 1'b0;
    end else begin
      card_valid_reg <= take_card;
      deal_err_reg   <= (state_reg == IDLE) && !shuffle && deal_req && shoe_empty;
      if (shuffle) begin
        cards_left_reg <= SHOE_FULL;
        card_reg       <= 4'd0;
      end else if (take_card) begin
        cards_left_reg <= cards_left_reg - 9'd1;
        card_reg       <= cand_reg;
      end
    end
  end

  assign card       = card_reg;
  assign card_valid = card_valid_reg;
  assign deal_err   = deal_err_reg;
  assign cards_left = cards_left_reg;
  assign shoe_empty = (cards_left_reg == 9'd0);

endmodule

// File: tb/tb_shoe_dealer.sv
// Directed bench for shoe_dealer: reset, single deals, rank skipping/wrap,
// full depletion, shuffle abort and mid-search asynchronous reset.
module tb_shoe_dealer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       deal_req = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] card, card8;
  logic       card_valid, card_valid8;
  logic       deal_err, deal_err8;
  logic       busy, busy8;
  logic       shoe_empty, shoe_empty8;
  logic [8:0] cards_left, cards_left8;

  int passed = 0;
  int total  = 0;
  int exp_ctr;
  int exp_count [1:13];
  int exp_left;

  always #5 clock = ~clock;

  shoe_dealer #(.NUM_DECKS(1)) dut (
    .clock(clock), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .card(card), .card_valid(card_valid), .deal_err(deal_err), .busy(busy),
    .shoe_empty(shoe_empty), .cards_left(cards_left)
  );

  shoe_dealer #(.NUM_DECKS(8)) dut8 (
    .clock(clock), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .card(card8), .card_valid(card_valid8), .deal_err(deal_err8), .busy(busy8),
    .shoe_empty(shoe_empty8), .cards_left(cards_left8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    exp_ctr = (exp_ctr == 13) ? 1 : exp_ctr + 1;
    @(negedge clock);
  endtask

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) exp_count[r] = 4;
    exp_left = 52;
  endtask

  function automatic int find_rank(input int r, output int m);
    m = 0;
    for (int i = 0; i < 13; i++) begin
      int rr;
      rr = ((r - 1 + i) % 13) + 1;
      if (exp_count[rr] > 0) begin
        m = i;
        return rr;
      end
    end
    return 0;
  endfunction

  // Request one card when the rank counter shows r; returns dealt card and edge latency.
  task automatic do_deal(input int r, output int got, output int lat);
    int guard;
    int m;
    int exp_card;
    guard = 0;
    while (exp_ctr != r && guard < 20) begin
      tick();
      guard++;
    end
    exp_card = find_rank(r, m);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("busy_after_req", 32'(busy), 1);
    lat = 1;
    while (!card_valid && lat < 16) begin
      tick();
      lat++;
    end
    chk("card_valid_seen", 32'(card_valid), 1);
    got = card_valid ? int'(card) : 0;
    chk("deal_card", got, exp_card);
    chk("deal_latency", lat, 2 + m);
    if (exp_card != 0) exp_count[exp_card]--;
    exp_left--;
    chk("deal_cards_left", 32'(cards_left), exp_left);
    $display("deal: req_rank=%0d card=%0d latency=%0d cards_left=%0d", r, got, lat, cards_left);
  endtask

  initial begin
    int got, lat, dealt, cyc, bad, last;
    int tally [1:13];

    // 1. reset values and rank counter sequence
    model_refill();
    @(negedge clock);
    @(negedge clock);
    chk("rst_cards_left", 32'(cards_left), 52);
    chk("rst_card", 32'(card), 0);
    chk("rst_card_valid", 32'(card_valid), 0);
    chk("rst_shoe_empty", 32'(shoe_empty), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_deal_err", 32'(deal_err), 0);
    chk("rst_cards_left_8deck", 32'(cards_left8), 416);
    reset = 1'b0;
    exp_ctr = 1;
    chk("rank_ctr_start", 32'(dut.rank_ctr_reg), 1);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("rank_ctr_seq", 32'(dut.rank_ctr_reg), exp_ctr);
    end
    chk("rank_ctr_wrap", 32'(dut.rank_ctr_reg), 1);

    // 2. single deal at rank 5
    do_deal(5, got, lat);
    chk("t2_card", got, 5);
    chk("t2_latency", lat, 2);
    chk("t2_cards_left", 32'(cards_left), 51);
    chk("t2_busy_cleared", 32'(busy), 0);
    tick();
    chk("t2_valid_one_cycle", 32'(card_valid), 0);
    chk("t2_card_holds", 32'(card), 5);

    // 3. deplete rank 7, skip to 8; deplete 7..13 and wrap to 1
    for (int i = 0; i < 4; i++) do_deal(7, got, lat);
    do_deal(7, got, lat);
    chk("t3_skip_card", got, 8);
    chk("t3_skip_latency", lat, 3);
    while (exp_count[8] + exp_count[9] + exp_count[10] + exp_count[11] +
           exp_count[12] + exp_count[13] > 0) do_deal(8, got, lat);
    do_deal(13, got, lat);
    chk("t3_wrap_card", got, 1);
    chk("t3_wrap_latency", lat, 3);
    chk("t3_cards_left", 32'(cards_left), 22);

    // 4. shuffle, then hold deal_req through the whole shoe
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_refill();
    chk("t4_shuffle_left", 32'(cards_left), 52);
    chk("t4_shuffle_card", 32'(card), 0);
    for (int r = 1; r <= 13; r++) tally[r] = 0;
    dealt = 0;
    cyc = 0;
    last = 0;
    deal_req = 1'b1;
    while (dealt < 52 && cyc < 2000) begin
      tick();
      cyc++;
      if (card_valid) begin
        if (card >= 4'd1 && card <= 4'd13) tally[card]++;
        last = int'(card);
        dealt++;
      end
    end
    $display("hold: dealt=%0d cycles=%0d cards_left=%0d", dealt, cyc, cards_left);
    chk("t4_deals_done", dealt, 52);
    chk("t4_shoe_empty", 32'(shoe_empty), 1);
    chk("t4_cards_left_zero", 32'(cards_left), 0);
    bad = 0;
    for (int r = 1; r <= 13; r++) if (tally[r] != 4) bad++;
    chk("t4_rank_tally_bad", bad, 0);
    tick();
    chk("t4_deal_err", 32'(deal_err), 1);
    chk("t4_no_valid", 32'(card_valid), 0);
    chk("t4_card_holds", 32'(card), last);
    deal_req = 1'b0;
    tick();
    chk("t4_deal_err_pulse", 32'(deal_err), 0);
    chk("t4_busy_idle", 32'(busy), 0);

    // 5. shuffle aborting a search; shuffle beating deal_req in IDLE
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_refill();
    do_deal(3, got, lat);
    chk("t5_pre_card", got, 3);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("t5_in_search", 32'(busy), 1);
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    model_refill();
    chk("t5_abort_no_valid", 32'(card_valid), 0);
    chk("t5_abort_left", 32'(cards_left), 52);
    chk("t5_abort_card", 32'(card), 0);
    chk("t5_abort_idle", 32'(busy), 0);
    tick();
    chk("t5_abort_no_late_valid", 32'(card_valid), 0);
    do_deal(4, got, lat);
    chk("t5_pre2_card", got, 4);
    deal_req = 1'b1;
    shuffle = 1'b1;
    tick();
    deal_req = 1'b0;
    shuffle = 1'b0;
    model_refill();
    chk("t5_both_idle", 32'(busy), 0);
    chk("t5_both_left", 32'(cards_left), 52);
    chk("t5_both_card", 32'(card), 0);
    tick();
    chk("t5_both_no_valid", 32'(card_valid), 0);
    chk("t5_both_no_err", 32'(deal_err), 0);

    // 6. asynchronous reset between edges while searching
    do_deal(6, got, lat);
    chk("t6_pre_card", got, 6);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("t6_in_search", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_card", 32'(card), 0);
    chk("t6_async_valid", 32'(card_valid), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_left", 32'(cards_left), 52);
    chk("t6_async_rank_ctr", 32'(dut.rank_ctr_reg), 1);
    chk("t6_async_left_8deck", 32'(cards_left8), 416);
    @(negedge clock);
    reset = 1'b0;
    exp_ctr = 1;
    model_refill();
    tick();
    chk("t6_post_valid", 32'(card_valid), 0);
    chk("t6_post_left", 32'(cards_left), 52);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
